step_arbiter: RTL and testbench
===============================

Name: step_arbiter

Overview:
- Shares one modulo-MOD step counter between N_REQ requesters, each issuing step commands: hold, +1, +2 or -1.
- Round-robin arbitration with a req/ack handshake and one transaction in flight at a time.
- A synchronous Clear overrides any pending arithmetic.
- Sits between the board-level request sources (debounced KEY/SW logic) and the b2d_ssd display driver, which shows count.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, requester-index width; 2**IDW >= N_REQ required.
- MOD, 10, counter modulus (3..2**CW).
- CW, 4, counter width.

Ports:
- Clock  in  1  system clock, rising-edge.
- Resetn  in  1  asynchronous, active-low reset.
- Clear  in  1  synchronous clear of count, sampled every edge.
- req  in  N_REQ  per-requester request; held high until its ack.
- op  in  2*N_REQ  per-requester command; op[2i+1:2i] belongs to requester i. Encoding: 0 = hold, 1 = +1, 2 = +2, 3 = -1.
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- grant_id  out  IDW  index of the current or most recent winner.
- busy  out  1  high while a transaction is in EXEC or ACK.
- count  out  CW  current counter value, always in 0..MOD-1.

Behaviour:
Reset (Resetn low, asynchronous):
- count=0, ack=0, busy=0, state=IDLE.
- grant_id=N_REQ-1, so requester 0 wins first.
- Latched op=0, done mask=0.

State machine (registered states IDLE, EXEC, ACK):
- IDLE: eligible = req & ~done.
  - If eligible is nonzero: pick the first set bit searching upward from grant_id+1, wrapping at N_REQ.
  - Latch winner into grant_id and its op into op_r; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC: apply op_r to count at this edge; go to ACK.
- ACK: ack[grant_id]=1 for exactly this cycle; set done[grant_id]; go to IDLE.
- busy = (state != IDLE).

Latency and handshake:
- Req seen in IDLE at edge t: count updates at edge t+1, ack is high during the cycle after edge t+1, next grant at edge t+3 at the earliest.
- One transaction per 3 cycles.
- An op is always acked, including op=0, where count is unchanged.

Done mask:
- done[i] clears on any edge where req[i]=0.
- A requester still holding req after its ack is not re-granted until it drops req for at least one cycle.
- If req[i] drops while i is in flight: the latched op still applies and ack still pulses.
- op changes after the grant are ignored.

Arithmetic (no intermediate overflow of CW bits):
- +1: count==MOD-1 gives 0, else count+1.
- +2: count>=MOD-2 gives count+2-MOD, else count+2.
- -1: count==0 gives MOD-1, else count-1.

Clear:
- Clear high at an edge sets count=0 at that edge, with priority over an EXEC update; that op is discarded.
- Clear does not alter the state machine, grant_id, done or ack. An in-flight transaction still reaches ACK and pulses ack.
- Clear in IDLE does not block a grant at the same edge.

Reset mid-operation:
- Returns everything to reset values immediately.
- Any ack in progress is dropped; the aborted transaction is never acked.

Test Plan:
1. Reset: hold Resetn=0 with random req/op -> count=0, ack=0, busy=0, grant_id=3. Release, req[2]=1 with op=1 -> grant_id=2, count=1 one edge after EXEC, ack=0100 for exactly one cycle.
2. Wrap arithmetic: single requester, from count=9: +1 -> 0; from 8: +2 -> 0; from 9: +2 -> 1; from 0: -1 -> 9; op=0 from 5 -> 5 with ack still pulsed.
3. Round-robin: all four req held high with op=1, each dropping req for one cycle after its ack and re-raising it -> grant order 0,1,2,3,0,1; count advances by 1 every 3 cycles; never two ack bits set at once.
4. Held request: req[1] held high continuously after its ack, others low -> no second grant. Drop req[1] one cycle, raise again -> granted again.
5. Clear in EXEC: count=7, req[0] op=2, Clear=1 on the EXEC edge -> count=0 (not 9), ack[0] still pulses the next cycle. Clear alone in IDLE from 4 -> 0 with no ack.
6. Async reset mid-transaction: pull Resetn low during ACK -> ack falls immediately, count=0, state=IDLE. After release, a fresh req[3] is granted normally.

Source files
------------

// File: rtl/step_arbiter_if.sv
// Request/command bus between the step requesters and the shared step counter.
// The master drives req/op; the slave (arbiter) returns ack, grant, busy and count.
interface step_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned CW    = 4
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] op;
    logic [N_REQ-1:0]   ack;
    logic [IDW-1:0]     grant_id;
    logic               busy;
    logic [CW-1:0]      count;

    modport master (
        output req,
        output op,
        input  ack,
        input  grant_id,
        input  busy,
        input  count
    );

    modport slave (
        input  req,
        input  op,
        output ack,
        output grant_id,
        output busy,
        output count
    );
endinterface

// File: rtl/step_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters step a shared modulo-MOD counter
// by hold/+1/+2/-1, one transaction at a time, with a synchronous Clear override.
module step_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned MOD   = 10,
    parameter int unsigned CW    = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Clear,
    step_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

    localparam logic [1:0] OpHold = 2'd0;
    localparam logic [1:0] OpInc1 = 2'd1;
    localparam logic [1:0] OpInc2 = 2'd2;
    localparam logic [1:0] OpDec1 = 2'd3;

    state_e            state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [1:0]        op_q, op_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [CW-1:0]     count_q, count_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  ack;
    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic [CW-1:0]     count_step;

    // Search upward from the slot after the last winner, wrapping at N_REQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = grant_q;
        eligible  = bus.req & ~done_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(grant_q) + k) % N_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    // Wrap comparisons are done before adding so nothing overflows CW bits.
    always_comb begin
        count_step = count_q;
        unique case (op_q)
            OpHold: count_step = count_q;
            OpInc1: count_step = (count_q == CW'(MOD - 1)) ? '0 : count_q + CW'(1);
            OpInc2: count_step = (count_q >= CW'(MOD - 2)) ? count_q - CW'(MOD - 2)
                                                           : count_q + CW'(2);
            OpDec1: count_step = (count_q == '0) ? CW'(MOD - 1) : count_q - CW'(1);
            default: count_step = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op_d    = op_q;
        count_d = count_q;
        done_d  = done_q & bus.req;
        ack     = '0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d = win_id;
                    op_d    = bus.op[{win_id, 1'b0} +: 2];
                    state_d = StExec;
                end
            end
            StExec: begin
                count_d = count_step;
                state_d = StAck;
            end
            StAck: begin
                ack[grant_q]    = 1'b1;
                // A requester that already dropped req is not marked done.
                done_d[grant_q] = bus.req[grant_q];
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (Clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            grant_q <= IDW'(N_REQ - 1);
            op_q    <= OpHold;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign bus.ack      = ack;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.count    = count_q;

    ack_onehot_a: assert property (@(posedge Clock) disable iff (!Resetn) $onehot0(ack));
    count_range_a: assert property (@(posedge Clock) disable iff (!Resetn)
                                    32'(count_q) < MOD);

endmodule

// File: tb/tb_step_arbiter.sv
// Directed bench for step_arbiter: a timeline-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_step_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int MOD = 10;
    localparam int CW  = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic Clear  = 1'b0;

    always #5 Clock = ~Clock;

    step_arbiter_if #(.N_REQ(N), .IDW(IDW), .CW(CW)) bus ();

    step_arbiter #(.N_REQ(N), .IDW(IDW), .MOD(MOD), .CW(CW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Clear  (Clear),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a grant at edge t0 updates count at t0+1, acks during the following
    // cycle and frees the arbiter at t0+2.
    int m_count = 0;
    int m_grant = N - 1;
    int m_op    = 0;
    int cyc     = 0;
    int t0      = 0;
    bit in_flight = 1'b0;
    bit m_done [N];
    bit m_found, m_fin, m_free;
    int m_w, m_idx;

    function automatic int apply_op(input int c, input int o);
        int delta;
        case (o)
            1: delta = 1;
            2: delta = 2;
            3: delta = -1;
            default: delta = 0;
        endcase
        return (c + delta + MOD) % MOD;
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_count   = 0;
            m_grant   = N - 1;
            m_op      = 0;
            cyc       = 0;
            t0        = 0;
            in_flight = 1'b0;
            for (int i = 0; i < N; i++) m_done[i] = 1'b0;
        end else begin
            cyc++;
            m_free  = !in_flight;
            m_found = 1'b0;
            m_fin   = 1'b0;
            m_w     = 0;
            if (m_free) begin
                for (int k = 1; k <= N; k++) begin
                    m_idx = (m_grant + k) % N;
                    if (!m_found && bus.req[m_idx] && !m_done[m_idx]) begin
                        m_found = 1'b1;
                        m_w     = m_idx;
                    end
                end
            end
            if (in_flight && cyc - t0 == 1) m_count = apply_op(m_count, m_op);
            if (in_flight && cyc - t0 == 2) begin
                in_flight = 1'b0;
                m_fin     = 1'b1;
            end
            for (int i = 0; i < N; i++) if (!bus.req[i]) m_done[i] = 1'b0;
            if (m_fin && bus.req[m_grant]) m_done[m_grant] = 1'b1;
            if (m_found) begin
                m_grant   = m_w;
                m_op      = int'(bus.op[2*m_w +: 2]);
                in_flight = 1'b1;
                t0        = cyc;
            end
            if (Clear) m_count = 0;
        end
    end

    always @(posedge Clock) begin
        logic [N-1:0] e_ack;
        #1;
        if (Resetn) begin
            e_ack = (in_flight && cyc - t0 == 1) ? N'(1 << m_grant) : '0;
            chk("cyc_count", 32'(bus.count), m_count);
            chk("cyc_busy", 32'(bus.busy), 32'(in_flight));
            chk("cyc_grant", 32'(bus.grant_id), m_grant);
            chk("cyc_ack", 32'(bus.ack), 32'(e_ack));
            chk("cyc_ack_onehot", 32'($countones(bus.ack) <= 1), 1);
        end
    end

    task automatic xact(input int id, input logic [1:0] o,
                        output logic [N-1:0] ack_seen, output logic [CW-1:0] cnt);
        bit got;
        got      = 1'b0;
        ack_seen = '0;
        cnt      = '0;
        @(negedge Clock);
        bus.req[id]       = 1'b1;
        bus.op[2*id +: 2] = o;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (bus.ack != '0) begin
                got      = 1'b1;
                ack_seen = bus.ack;
                cnt      = bus.count;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        bus.req[id] = 1'b0;
        @(negedge Clock);
        chk("ack_one_cycle", 32'(bus.ack), 0);
    endtask

    task automatic clear_pulse();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        chk("clear_count", 32'(bus.count), 0);
        chk("clear_no_ack", 32'(bus.ack), 0);
    endtask

    int t2_op  [10] = '{3, 1, 3, 3, 2, 3, 2, 2, 2, 0};
    int t2_exp [10] = '{9, 0, 9, 8, 0, 9, 1, 3, 5, 5};
    int rr_exp [6]  = '{0, 1, 2, 3, 0, 1};

    initial begin
        logic [N-1:0]  a;
        logic [CW-1:0] c;
        logic [N-1:0]  pend;
        int order [$];
        int ack_cyc [$];
        int acks;
        bit got;

        bus.req = '0;
        bus.op  = '0;

        // 1: reset with random inputs, then first grant to requester 2
        repeat (4) begin
            @(negedge Clock);
            bus.req = N'($urandom);
            bus.op  = (2*N)'($urandom);
        end
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_grant", 32'(bus.grant_id), 3);
        @(negedge Clock);
        bus.req = '0;
        bus.op  = '0;
        Resetn  = 1'b1;
        xact(2, 2'd1, a, c);
        chk("t1_ack", 32'(a), 32'(4'b0100));
        chk("t1_count", 32'(c), 1);
        chk("t1_grant", 32'(bus.grant_id), 2);

        // 2: wrap arithmetic on requester 0
        clear_pulse();
        for (int i = 0; i < 10; i++) begin
            xact(0, t2_op[i][1:0], a, c);
            chk($sformatf("t2_count_%0d", i), 32'(c), t2_exp[i]);
            chk($sformatf("t2_ack_%0d", i), 32'(a), 32'(4'b0001));
        end

        // 3: round-robin, each requester drops req for one cycle after its ack
        xact(3, 2'd0, a, c);
        chk("t3_pre_count", 32'(c), 5);
        @(negedge Clock);
        bus.req = 4'hF;
        bus.op  = 8'b01010101;
        pend    = '0;
        for (int i = 0; i < 60 && order.size() < 6; i++) begin
            @(negedge Clock);
            bus.req = bus.req | pend;
            pend    = '0;
            if (bus.ack != '0) begin
                for (int b = 0; b < N; b++) if (bus.ack[b]) order.push_back(b);
                ack_cyc.push_back(i);
                pend    = bus.ack;
                bus.req = bus.req & ~bus.ack;
            end
        end
        bus.req = '0;
        chk("t3_acks", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++)
            chk($sformatf("t3_order_%0d", i), order[i], rr_exp[i]);
        for (int i = 1; i < ack_cyc.size(); i++)
            chk($sformatf("t3_gap_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        @(negedge Clock);
        chk("t3_count", 32'(bus.count), 1);

        // 4: held request is granted once, then again only after a drop
        @(negedge Clock);
        bus.req[1]  = 1'b1;
        bus.op[3:2] = 2'd1;
        acks = 0;
        repeat (12) begin
            @(negedge Clock);
            if (bus.ack[1]) acks++;
        end
        chk("t4_held_acks", acks, 1);
        chk("t4_count_a", 32'(bus.count), 2);
        bus.req[1] = 1'b0;
        @(negedge Clock);
        bus.req[1] = 1'b1;
        acks = 0;
        repeat (12) begin
            @(negedge Clock);
            if (bus.ack[1]) acks++;
        end
        chk("t4_regrant_acks", acks, 1);
        chk("t4_count_b", 32'(bus.count), 3);
        bus.req[1] = 1'b0;

        // 5: Clear on the EXEC edge discards +2; Clear alone in IDLE
        xact(0, 2'd2, a, c);
        xact(0, 2'd2, a, c);
        chk("t5_pre_count", 32'(c), 7);
        @(negedge Clock);
        bus.req[0]  = 1'b1;
        bus.op[1:0] = 2'd2;
        @(negedge Clock);
        chk("t5_busy", 32'(bus.busy), 1);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        chk("t5_clear_exec_count", 32'(bus.count), 0);
        chk("t5_clear_exec_ack", 32'(bus.ack), 32'(4'b0001));
        bus.req[0] = 1'b0;
        @(negedge Clock);
        chk("t5_after_count", 32'(bus.count), 0);
        xact(0, 2'd2, a, c);
        xact(0, 2'd2, a, c);
        chk("t5_idle_pre", 32'(c), 4);
        clear_pulse();

        // 6: async reset during ACK drops the ack; fresh req[3] then wins
        @(negedge Clock);
        bus.req[3]  = 1'b1;
        bus.op[7:6] = 2'd1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (bus.ack != '0) got = 1'b1;
        end
        chk("t6_ack_seen", 32'(got), 1);
        chk("t6_pre_count", 32'(bus.count), 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("t6_rst_ack", 32'(bus.ack), 0);
        chk("t6_rst_count", 32'(bus.count), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_grant", 32'(bus.grant_id), 3);
        bus.req = '0;
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        xact(3, 2'd1, a, c);
        chk("t6_ack", 32'(a), 32'(4'b1000));
        chk("t6_count", 32'(c), 1);
        chk("t6_grant", 32'(bus.grant_id), 3);

        repeat (2) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
